// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared types and helpers for the PWM setpoint ramp sequencer.
// The setpoint is one direction bit above a 7-bit magnitude.
package pwm_ctrl_pkg;

  localparam int DIR_BIT = 7;
  localparam int MAG_W   = 7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RAMP  = 3'd1,
    BRAKE = 3'd2,
    DWELL = 3'd3,
    ESTOP = 3'd4
  } state_e;

  typedef struct packed {
    logic             dir;
    logic [MAG_W-1:0] mag;
  } setpt_t;

  localparam logic [MAG_W-1:0] MAG_ZERO = {MAG_W{1'b0}};

  // Move mag toward goal by at most step. The arithmetic is 8 bits wide, so
  // the result can neither overshoot the goal nor wrap.
  function automatic logic [MAG_W-1:0] step_toward(input logic [MAG_W-1:0] mag,
                                                   input logic [MAG_W-1:0] goal,
                                                   input logic [7:0]       step);
    logic [7:0] m8;
    logic [7:0] g8;
    logic [7:0] diff;
    logic [7:0] res;
    m8 = {1'b0, mag};
    g8 = {1'b0, goal};
    if (g8 > m8) begin
      diff = g8 - m8;
      if (diff > step) diff = step;
      res = m8 + diff;
    end else begin
      diff = m8 - g8;
      if (diff > step) diff = step;
      res = m8 - diff;
    end
    return res[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Command handshake between a setpoint source and pwm_ramp_ctrl.
interface pwm_ramp_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_setpt;

  modport master (output cmd_valid, output cmd_setpt, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_setpt, output cmd_ready);
endinterface

// File: rtl/pwm_ramp_ctrl_tick_div.sv
// Rising-edge detector on tick_in feeding a clearable modulo-N counter.
// update pulses on the tick rise that wraps the counter.
module pwm_tick_div #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_in,
  input  logic en,
  input  logic clr,
  output logic update
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic          tick_q;
  logic          tick_rise;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_rise = tick_in & ~tick_q;
  assign update    = en & tick_rise & (cnt_q == LAST);

  // Clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (en && tick_rise) begin
      cnt_d = (cnt_q == LAST) ? {CW{1'b0}} : cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
      cnt_q  <= {CW{1'b0}};
    end else begin
      tick_q <= tick_in;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Slews the applied PWM setpoint toward a commanded target at a fixed rate.
// A reversal brakes to zero and dwells there before the direction flips; estop forces zero.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int STEP      = 4,
  parameter int RAMP_DIV  = 2,
  parameter int REV_DWELL = 3
) (
  input  logic                  clk_256k,
  input  logic                  rst_n,
  input  logic                  tick_in,
  input  logic                  estop,
  pwm_ramp_ctrl_if.slave        cmd,
  output logic [7:0]            setpt_cnt_out,
  output logic                  busy,
  output logic                  at_target
);

  state_e           state_q, state_d;
  setpt_t           out_q, out_d;
  setpt_t           tgt_q, tgt_d;
  logic             busy_q, busy_d;
  logic             at_target_q, at_target_d;
  logic             dirs_differ;
  logic [MAG_W-1:0] goal;
  logic [MAG_W-1:0] new_mag;
  logic             ramp_en, ramp_clr, ramp_upd;
  logic             dwell_en, dwell_clr, dwell_upd;

  assign cmd.cmd_ready = ~estop;

  assign ramp_en   = (state_q == RAMP) || (state_q == BRAKE);
  assign ramp_clr  = (state_d != RAMP) && (state_d != BRAKE);
  assign dwell_en  = (state_q == DWELL);
  assign dwell_clr = (state_d != DWELL);

  pwm_tick_div #(.N(RAMP_DIV)) u_ramp_div (
    .clk     (clk_256k),
    .rst_n   (rst_n),
    .tick_in (tick_in),
    .en      (ramp_en),
    .clr     (ramp_clr),
    .update  (ramp_upd)
  );

  pwm_tick_div #(.N(REV_DWELL)) u_dwell_div (
    .clk     (clk_256k),
    .rst_n   (rst_n),
    .tick_in (tick_in),
    .en      (dwell_en),
    .clr     (dwell_clr),
    .update  (dwell_upd)
  );

  // While directions disagree the goal is zero, so RAMP and BRAKE share one
  // datapath. The decision uses the registered target, which means a command
  // on an update edge only takes effect from the next update.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    tgt_d       = tgt_q;
    dirs_differ = (tgt_q.dir != out_q.dir);
    goal        = dirs_differ ? MAG_ZERO : tgt_q.mag;
    new_mag     = ramp_upd ? step_toward(out_q.mag, goal, 8'(STEP)) : out_q.mag;

    if (estop) begin
      state_d   = ESTOP;
      out_d.mag = MAG_ZERO;
      tgt_d.dir = out_q.dir;
      tgt_d.mag = MAG_ZERO;
    end else begin
      if (cmd.cmd_valid) begin
        tgt_d = setpt_t'(cmd.cmd_setpt);
      end else begin
        tgt_d = tgt_q;
      end
      case (state_q)
        IDLE: begin
          if (dirs_differ) begin
            state_d = (out_q.mag != MAG_ZERO) ? BRAKE : DWELL;
          end else if (tgt_q.mag != out_q.mag) begin
            state_d = RAMP;
          end else begin
            state_d = IDLE;
          end
        end
        RAMP, BRAKE: begin
          out_d.mag = new_mag;
          if (dirs_differ) begin
            state_d = (new_mag == MAG_ZERO) ? DWELL : BRAKE;
          end else if (new_mag == tgt_q.mag) begin
            state_d = IDLE;
          end else begin
            state_d = RAMP;
          end
        end
        DWELL: begin
          // The dwell runs to completion even if the target direction reverts.
          if (dwell_upd) begin
            out_d.dir = tgt_q.dir;
            state_d   = (tgt_q.mag == MAG_ZERO) ? IDLE : RAMP;
          end else begin
            state_d = DWELL;
          end
        end
        ESTOP:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d      = (state_d == RAMP) || (state_d == BRAKE) || (state_d == DWELL);
    at_target_d = (state_d == IDLE) && (out_d == tgt_d);
  end

  // State and output registers.
  always_ff @(posedge clk_256k or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_q       <= setpt_t'(8'h00);
      tgt_q       <= setpt_t'(8'h00);
      busy_q      <= 1'b0;
      at_target_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      tgt_q       <= tgt_d;
      busy_q      <= busy_d;
      at_target_q <= at_target_d;
    end
  end

  assign setpt_cnt_out = out_q;
  assign busy          = busy_q;
  assign at_target     = at_target_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed table-driven bench for pwm_ramp_ctrl with STEP=4, RAMP_DIV=2, REV_DWELL=3.
module tb_pwm_ramp_ctrl;

  localparam int ACT_NONE = 0;
  localparam int ACT_CMD  = 1;
  localparam int ACT_EON  = 2;
  localparam int ACT_EOFF = 3;

  typedef struct {
    int         act;
    logic [7:0] sp;
    int         rises;
    logic [7:0] exp_out;
    logic       exp_busy;
    logic       exp_at;
    logic       exp_rdy;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       tick_in;
  logic       estop;
  logic [7:0] setpt_cnt_out;
  logic       busy;
  logic       at_target;
  int         n_vec;
  int         n_err;
  vec_t       tv[31];

  pwm_ramp_ctrl_if cmd_if();

  pwm_ramp_ctrl #(.STEP(4), .RAMP_DIV(2), .REV_DWELL(3)) dut (
    .clk_256k      (clk),
    .rst_n         (rst_n),
    .tick_in       (tick_in),
    .estop         (estop),
    .cmd           (cmd_if),
    .setpt_cnt_out (setpt_cnt_out),
    .busy          (busy),
    .at_target     (at_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int act, logic [7:0] sp, int rises, logic [7:0] o,
                              logic b, logic a, logic r);
    vec_t v;
    v.act = act; v.sp = sp; v.rises = rises; v.exp_out = o;
    v.exp_busy = b; v.exp_at = a; v.exp_rdy = r;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] o, input logic b,
                         input logic a, input logic r);
    chk({tag, " out"}, setpt_cnt_out, o);
    chk({tag, " busy"}, {7'd0, busy}, {7'd0, b});
    chk({tag, " at_target"}, {7'd0, at_target}, {7'd0, a});
    chk({tag, " cmd_ready"}, {7'd0, cmd_if.cmd_ready}, {7'd0, r});
  endtask

  // One ideal tick period; leaves tick high, sampling point is a falling clock edge.
  task automatic rise();
    @(negedge clk) tick_in = 1'b0;
    repeat (64) @(negedge clk);
    tick_in = 1'b1;
    repeat (64) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] sp);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_setpt = sp;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    tick_in = 1'b0;
    estop = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_setpt = 8'h00;

    tv[0]  = mk(ACT_CMD,  8'h10, 0, 8'h00, 1'b1, 1'b0, 1'b1);
    tv[1]  = mk(ACT_NONE, 8'h00, 1, 8'h00, 1'b1, 1'b0, 1'b1);
    tv[2]  = mk(ACT_NONE, 8'h00, 1, 8'h04, 1'b1, 1'b0, 1'b1);
    tv[3]  = mk(ACT_NONE, 8'h00, 2, 8'h08, 1'b1, 1'b0, 1'b1);
    tv[4]  = mk(ACT_NONE, 8'h00, 2, 8'h0C, 1'b1, 1'b0, 1'b1);
    tv[5]  = mk(ACT_NONE, 8'h00, 2, 8'h10, 1'b0, 1'b1, 1'b1);
    tv[6]  = mk(ACT_CMD,  8'h00, 8, 8'h00, 1'b0, 1'b1, 1'b1);
    tv[7]  = mk(ACT_CMD,  8'h0A, 2, 8'h04, 1'b1, 1'b0, 1'b1);
    tv[8]  = mk(ACT_NONE, 8'h00, 2, 8'h08, 1'b1, 1'b0, 1'b1);
    tv[9]  = mk(ACT_NONE, 8'h00, 2, 8'h0A, 1'b0, 1'b1, 1'b1);
    tv[10] = mk(ACT_CMD,  8'h00, 2, 8'h06, 1'b1, 1'b0, 1'b1);
    tv[11] = mk(ACT_NONE, 8'h00, 2, 8'h02, 1'b1, 1'b0, 1'b1);
    tv[12] = mk(ACT_NONE, 8'h00, 2, 8'h00, 1'b0, 1'b1, 1'b1);
    tv[13] = mk(ACT_CMD,  8'h10, 4, 8'h08, 1'b1, 1'b0, 1'b1);
    tv[14] = mk(ACT_CMD,  8'h09, 2, 8'h09, 1'b0, 1'b1, 1'b1);
    tv[15] = mk(ACT_CMD,  8'h10, 2, 8'h0D, 1'b1, 1'b0, 1'b1);
    tv[16] = mk(ACT_NONE, 8'h00, 2, 8'h10, 1'b0, 1'b1, 1'b1);
    tv[17] = mk(ACT_CMD,  8'h88, 8, 8'h00, 1'b1, 1'b0, 1'b1);
    tv[18] = mk(ACT_NONE, 8'h00, 2, 8'h00, 1'b1, 1'b0, 1'b1);
    tv[19] = mk(ACT_NONE, 8'h00, 1, 8'h80, 1'b1, 1'b0, 1'b1);
    tv[20] = mk(ACT_NONE, 8'h00, 2, 8'h84, 1'b1, 1'b0, 1'b1);
    tv[21] = mk(ACT_NONE, 8'h00, 2, 8'h88, 1'b0, 1'b1, 1'b1);
    tv[22] = mk(ACT_CMD,  8'h08, 2, 8'h84, 1'b1, 1'b0, 1'b1);
    tv[23] = mk(ACT_CMD,  8'h8C, 2, 8'h88, 1'b1, 1'b0, 1'b1);
    tv[24] = mk(ACT_NONE, 8'h00, 2, 8'h8C, 1'b0, 1'b1, 1'b1);
    tv[25] = mk(ACT_EON,  8'h00, 0, 8'h80, 1'b0, 1'b0, 1'b0);
    tv[26] = mk(ACT_CMD,  8'h20, 0, 8'h80, 1'b0, 1'b0, 1'b0);
    tv[27] = mk(ACT_EOFF, 8'h00, 2, 8'h80, 1'b0, 1'b1, 1'b1);
    tv[28] = mk(ACT_CMD,  8'h10, 2, 8'h80, 1'b1, 1'b0, 1'b1);
    tv[29] = mk(ACT_NONE, 8'h00, 1, 8'h00, 1'b1, 1'b0, 1'b1);
    tv[30] = mk(ACT_NONE, 8'h00, 2, 8'h04, 1'b1, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    chk_all("reset", 8'h00, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_all("post-reset", 8'h00, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 31; i++) begin
      case (tv[i].act)
        ACT_CMD:  send(tv[i].sp);
        ACT_EON:  begin @(negedge clk); estop = 1'b1; end
        ACT_EOFF: begin @(negedge clk); estop = 1'b0; end
        default:  @(negedge clk);
      endcase
      repeat (2) @(negedge clk);
      for (int r = 0; r < tv[i].rises; r++) rise();
      chk_all($sformatf("vec%0d", i), tv[i].exp_out, tv[i].exp_busy,
              tv[i].exp_at, tv[i].exp_rdy);
    end

    // Estop mid-ramp at 0x04: zero after one edge, ready drops combinationally.
    @(negedge clk);
    estop = 1'b1;
    #1;
    chk("estop ready comb", {7'd0, cmd_if.cmd_ready}, 8'h00);
    @(negedge clk);
    chk("estop one edge", setpt_cnt_out, 8'h00);
    estop = 1'b0;
    repeat (2) @(negedge clk);
    chk_all("estop release", 8'h00, 1'b0, 1'b1, 1'b1);

    // Estop and a command on the same edge: the command is lost.
    @(negedge clk);
    estop = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_setpt = 8'h30;
    @(negedge clk);
    estop = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rise();
    rise();
    chk_all("estop beats cmd", 8'h00, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset during DWELL, then no motion without a new command.
    send(8'h88);
    rise();
    chk("dwell busy", {7'd0, busy}, 8'h01);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out", setpt_cnt_out, 8'h00);
    chk("async rst busy", {7'd0, busy}, 8'h00);
    chk("async rst at_target", {7'd0, at_target}, 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) rise();
    chk_all("after reset idle", 8'h00, 1'b0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
